// File: rtl/sub16u_pipe_trunc.sv
// sub16u_pipe_trunc: two-stage truncated approximate unsigned subtractor.
// Ports: clk/rst, in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_d/out_apx.
module sub16u_pipe_trunc #(
  parameter int WIDTH = 16,
  parameter int TRUNC = 6,
  parameter int SPLIT = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_d,
  output logic             out_apx
);

  localparam int LW = SPLIT - TRUNC;
  localparam int HW = WIDTH - SPLIT;

  logic          s1_valid_q, s1_valid_d;
  logic [LW-1:0] s1_lo_q, s1_lo_d;
  logic          s1_b1_q, s1_b1_d;
  logic [HW-1:0] s1_ah_q, s1_ah_d;
  logic [HW-1:0] s1_bh_q, s1_bh_d;
  logic          s1_apx_q, s1_apx_d;

  logic          s2_valid_q, s2_valid_d;
  logic [WIDTH:0] out_d_q, out_d_d;
  logic          out_apx_q, out_apx_d;

  logic adv1, adv2, acc, apx;
  logic [LW:0]    lo_ext;
  logic [HW:0]    hi_ext;
  logic [WIDTH:0] res;

  if (TRUNC > 0) begin : g_apx
    assign apx = |{in_a[TRUNC-1:0], in_b[TRUNC-1:0]};
  end else begin : g_noapx
    assign apx = 1'b0;
  end

  assign adv2     = !s2_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;
  assign acc      = in_valid & adv1;

  // MSB of the widened difference is the borrow out of each segment.
  assign lo_ext = {1'b0, in_a[SPLIT-1:TRUNC]}
                - {1'b0, in_b[SPLIT-1:TRUNC]};
  assign hi_ext = {1'b0, s1_ah_q} - {1'b0, s1_bh_q}
                - {{HW{1'b0}}, s1_b1_q};

  always_comb begin
    res = '0;
    res[WIDTH:TRUNC] = {hi_ext, s1_lo_q};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_b1_d    = s1_b1_q;
    s1_ah_d    = s1_ah_q;
    s1_bh_d    = s1_bh_q;
    s1_apx_d   = s1_apx_q;
    s2_valid_d = s2_valid_q;
    out_d_d    = out_d_q;
    out_apx_d  = out_apx_q;
    if (adv1) begin
      s1_valid_d = in_valid;
    end
    if (acc) begin
      s1_lo_d  = lo_ext[LW-1:0];
      s1_b1_d  = lo_ext[LW];
      s1_ah_d  = in_a[WIDTH-1:SPLIT];
      s1_bh_d  = in_b[WIDTH-1:SPLIT];
      s1_apx_d = apx;
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d_d   = res;
        out_apx_d = s1_apx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_b1_q    <= 1'b0;
      s1_ah_q    <= '0;
      s1_bh_q    <= '0;
      s1_apx_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_d_q    <= '0;
      out_apx_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_b1_q    <= s1_b1_d;
      s1_ah_q    <= s1_ah_d;
      s1_bh_q    <= s1_bh_d;
      s1_apx_q   <= s1_apx_d;
      s2_valid_q <= s2_valid_d;
      out_d_q    <= out_d_d;
      out_apx_q  <= out_apx_d;
    end
  end

  // Suppress any output transfer while reset is held.
  assign out_valid = s2_valid_q & !rst;
  assign out_d     = out_d_q;
  assign out_apx   = out_apx_q;

endmodule

// File: tb/tb_sub16u_pipe_trunc.sv
// tb_sub16u_pipe_trunc: scoreboard bench for sub16u_pipe_trunc.
// Drives operand pairs, compares each result with a golden model.
module tb_sub16u_pipe_trunc;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_a = 0;
  logic [15:0] in_b = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [16:0] out_d;
  logic        out_apx;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  bit stall_seen = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sub16u_pipe_trunc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_apx(out_apx)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Truncate both operands, subtract the kept bits as one 11-bit field.
  function automatic logic [16:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    logic [10:0] dh;
    dh = {1'b0, a[15:6]} - {1'b0, b[15:6]};
    return {dh, 6'b0};
  endfunction

  logic        stalled = 0;
  logic [16:0] hold_d;
  logic        hold_apx;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (in_valid && !in_ready) stall_seen = 1;
      if (stalled && out_valid)
        check("hold", {14'b0, out_apx, out_d},
              {14'b0, hold_apx, hold_d});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          logic [31:0] e;
          logic [15:0] a, b;
          logic [16:0] m;
          int ex, er;
          e = exp_q.pop_front();
          a = e[31:16];
          b = e[15:0];
          m = model(a, b);
          n_out++;
          check("out_d", {15'b0, out_d}, {15'b0, m});
          check("out_apx", {31'b0, out_apx},
                {31'b0, (a[5:0] != 0) || (b[5:0] != 0)});
          if (!m[16]) begin
            ex = int'(a) - int'(b);
            er = ex - int'(out_d);
            if (er < 0) er = -er;
            check("err_bound", {31'b0, er < 64}, 1);
          end
        end
      end
      stalled = out_valid && !out_ready;
      hold_d = out_d;
      hold_apx = out_apx;
    end
  end

  task automatic push_in(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bit done = 0;
    in_valid = 1;
    in_a = a;
    in_b = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({a, b});
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin
        check("in_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 0;
  endtask

  task automatic lat_check(input logic [15:0] a, input logic [15:0] b);
    push_in(a, b);
    @(negedge clk);
    check("lat1", {31'b0, out_valid}, 0);
    @(negedge clk);
    check("lat2", {31'b0, out_valid}, 1);
    check("lat2_d", {15'b0, out_d}, {15'b0, model(a, b)});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ov", {31'b0, out_valid}, 0);
    check("rst_d", {15'b0, out_d}, 0);
    check("rst_apx", {31'b0, out_apx}, 0);
    check("rst_ir", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    lat_check(16'h1234, 16'h0234);
    check("t1_const", {15'b0, model(16'h1234, 16'h0234)}, 32'h01000);
    lat_check(16'h0800, 16'h0040);
    lat_check(16'h0040, 16'h0080);
    lat_check(16'hFFFF, 16'h0000);
    lat_check(16'hABC0, 16'hABC0);
    lat_check(16'h0000, 16'hFFFF);
    drain();

    n_out = 0;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push_in(16'h1000 * i[15:0] + 16'h0123, 16'h0841 * i[15:0]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("stream_n", n_out, 8);
    check("stream_stall", {31'b0, stall_seen}, 1);

    out_ready = 0;
    push_in(16'h5555, 16'h1111);
    push_in(16'h7777, 16'h2222);
    @(negedge clk);
    check("full_ir", {31'b0, in_ready}, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst6_ov", {31'b0, out_valid}, 0);
    check("rst6_ir", {31'b0, in_ready}, 1);
    out_ready = 1;
    repeat (4) @(negedge clk);
    check("rst6_stale", {31'b0, out_valid}, 0);
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          push_in(16'($urandom), 16'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    out_ready = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
